// File: rtl/entropy_decoder_mc.sv
// Multi-channel entropy decoder: sign-reconstructs (value, run, size) tokens, DC-predicts per channel
// and expands every block to BLOCK_SIZE zig-zag coefficients. ENTROPY_DECODER_MC_ERROR_EN adds token checks and error_out.

module entropy_decoder_mc_pred #(
  parameter int OUT_WIDTH = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [OUT_WIDTH-1:0] wr_data,
  output logic [OUT_WIDTH-1:0] pred
);
  // a DC write coinciding with clear wins: that token was already decoded against 0
  always_ff @(posedge clk_in) begin
    if (rst_in)     pred <= '0;
    else if (wr_en) pred <= wr_data;
    else if (clear) pred <= '0;
  end
endmodule

module entropy_decoder_mc #(
  parameter  int VALUE_WIDTH  = 11,
  parameter  int OUT_WIDTH    = 12,
  parameter  int NUM_CHANNELS = 3,
  parameter  int BLOCK_SIZE   = 64,
  parameter  int DELTA_DECODE = 1,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int IW = $clog2(BLOCK_SIZE)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic [IW-1:0]          run_in,
  input  logic [4:0]             size_in,
  input  logic                   dc_in,
  input  logic [CW-1:0]          channel_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic                   clear_pred_in,
  output logic [OUT_WIDTH-1:0]   coef_out,
  output logic [IW-1:0]          index_out,
  output logic [CW-1:0]          channel_out,
  output logic                   last_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   error_out
);
  typedef enum logic [1:0] {S_DC, S_AC, S_RUN, S_FILL} state_t;
  localparam int DW = VALUE_WIDTH + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);

  state_t                                 state;
  logic [IW-1:0]                          idx, idx_nxt, run_cnt;
  logic [OUT_WIDTH-1:0]                   pend, dec, pred_sel, dc_val;
  logic [VALUE_WIDTH-1:0]                 size_bit;
  logic [DW-1:0]                          val_ext, dec_w;
  logic [NUM_CHANNELS-1:0][OUT_WIDTH-1:0] pred_q;
  logic advance, accept, tok_ok, dc_take, at_last, ch_ok;

  assign advance   = !valid_out || ready_in;
  assign ready_out = advance && (state == S_DC || state == S_AC);
  assign accept    = valid_in && ready_out;
  assign at_last   = idx == LAST_IDX;
  assign idx_nxt   = at_last ? '0 : idx + IW'(1);

  // a clear top bit marks a negative code: value - 2^size + 1
  assign size_bit = VALUE_WIDTH'(1) << (size_in - 5'd1);
  assign val_ext  = DW'(value_in);
  assign dec_w    = (size_in == 5'd0) ? '0 :
                    (|(value_in & size_bit)) ? val_ext :
                    val_ext - (DW'(1) << size_in) + DW'(1);
  assign dec      = OUT_WIDTH'($signed(dec_w));

  assign ch_ok    = {1'b0, channel_in} < (CW+1)'(NUM_CHANNELS);
  assign pred_sel = (clear_pred_in || !ch_ok) ? '0 : pred_q[channel_in];
  assign dc_val   = (DELTA_DECODE != 0) ? dec + pred_sel : dec;
  assign dc_take  = accept && tok_ok && state == S_DC;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pred
    entropy_decoder_mc_pred #(.OUT_WIDTH(OUT_WIDTH)) u_pred (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clear   (clear_pred_in),
      .wr_en   (dc_take && channel_in == CW'(c)),
      .wr_data (dc_val),
      .pred    (pred_q[c])
    );
  end

`ifdef ENTROPY_DECODER_MC_ERROR_EN
  logic overrun, err_set;
  assign tok_ok  = dc_in == (state == S_DC);
  // a zero landing on the last index while run or value is still pending
  assign overrun = advance && at_last &&
                   ((state == S_AC && accept && tok_ok && run_in != '0) ||
                    (state == S_RUN && run_cnt != '0));
  assign err_set = (accept && !tok_ok) || overrun;

  always_ff @(posedge clk_in) begin
    if (rst_in)       error_out <= 1'b0;
    else if (err_set) error_out <= 1'b1;
  end
`else
  logic unused_dc;
  assign unused_dc = dc_in;
  assign tok_ok    = 1'b1;
  assign error_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_DC;
      idx         <= '0;
      run_cnt     <= '0;
      pend        <= '0;
      coef_out    <= '0;
      index_out   <= '0;
      channel_out <= '0;
      last_out    <= 1'b0;
      valid_out   <= 1'b0;
    end else if (advance) begin
      valid_out <= 1'b0;
      case (state)
        S_DC: if (accept && tok_ok) begin
          valid_out   <= 1'b1;
          coef_out    <= dc_val;
          index_out   <= idx;
          last_out    <= at_last;
          idx         <= idx_nxt;
          channel_out <= channel_in;
          state       <= at_last ? S_DC : S_AC;
        end
        S_AC: if (accept && tok_ok) begin
          valid_out <= 1'b1;
          index_out <= idx;
          last_out  <= at_last;
          idx       <= idx_nxt;
          if (run_in == '0) begin
            coef_out <= dec;
            state    <= at_last ? S_DC : (size_in == 5'd0) ? S_FILL : S_AC;
          end else begin
            coef_out <= '0;
            run_cnt  <= run_in - IW'(1);
            pend     <= dec;
            state    <= at_last ? S_DC : S_RUN;
          end
        end
        S_RUN: begin
          valid_out <= 1'b1;
          index_out <= idx;
          last_out  <= at_last;
          idx       <= idx_nxt;
          if (run_cnt != '0) begin
            coef_out <= '0;
            run_cnt  <= run_cnt - IW'(1);
            if (at_last) state <= S_DC;
          end else begin
            coef_out <= pend;
            state    <= at_last ? S_DC : S_AC;
          end
        end
        S_FILL: begin
          valid_out <= 1'b1;
          coef_out  <= '0;
          index_out <= idx;
          last_out  <= at_last;
          idx       <= idx_nxt;
          if (at_last) state <= S_DC;
        end
        default: state <= S_DC;
      endcase
    end
  end
endmodule

// File: tb/tb_entropy_decoder_mc.sv
// Directed bench for entropy_decoder_mc: expected coefficients are queued as tokens are driven
// and popped by a monitor on every output handshake.

module tb_entropy_decoder_mc;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] value_in;
  logic [5:0]  run_in;
  logic [4:0]  size_in;
  logic        dc_in;
  logic [1:0]  channel_in;
  logic        valid_in;
  logic        ready_out;
  logic        clear_pred_in;
  logic [11:0] coef_out;
  logic [5:0]  index_out;
  logic [1:0]  channel_out;
  logic        last_out;
  logic        valid_out;
  logic        ready_in;
  logic        error_out;

  typedef struct packed {
    logic [11:0] coef;
    logic [5:0]  idx;
    logic [1:0]  ch;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef ENTROPY_DECODER_MC_ERROR_EN
  localparam logic EXP_OVR_ERR = 1'b1;
`else
  localparam logic EXP_OVR_ERR = 1'b0;
`endif

  entropy_decoder_mc dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .value_in      (value_in),
    .run_in        (run_in),
    .size_in       (size_in),
    .dc_in         (dc_in),
    .channel_in    (channel_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .clear_pred_in (clear_pred_in),
    .coef_out      (coef_out),
    .index_out     (index_out),
    .channel_out   (channel_out),
    .last_out      (last_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .error_out     (error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int coef, input int idx, input int ch, input bit last);
    sb.push_back('{coef: 12'(coef), idx: 6'(idx), ch: 2'(ch), last: last});
  endtask

  task automatic push_zeros(input int from, input int to, input int ch);
    for (int i = from; i <= to; i++) push(0, i, ch, i == 63);
  endtask

  task automatic send(input bit dc, input int ch, input int sz, input int val, input int run);
    int n;
    valid_in   = 1'b1;
    dc_in      = dc;
    channel_in = 2'(ch);
    size_in    = 5'(sz);
    value_in   = 11'(val);
    run_in     = 6'(run);
    n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("accept_timeout", 64'(ready_out), 64'(1));
    @(posedge clk_in);
    #1;
    valid_in      = 1'b0;
    clear_pred_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'(0));
    @(posedge clk_in);
    #1;
  endtask

  // scoreboard: every output handshake must match the oldest queued expectation
  always @(negedge clk_in) begin
    if (!rst_in && valid_out && ready_in) begin
      if (sb.size() == 0) chk("unexpected_coef", 64'(valid_out), 64'(0));
      else chk("coef_idx_ch_last", 64'({coef_out, index_out, channel_out, last_out}), 64'(sb.pop_front()));
    end
  end

  initial begin
    rst_in = 1'b1; ready_in = 1'b1; valid_in = 1'b0; clear_pred_in = 1'b0;
    dc_in = 1'b0; channel_in = '0; size_in = '0; value_in = '0; run_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_last", 64'(last_out), 64'(0));
    chk("rst_coef", 64'(coef_out), 64'(0));
    chk("rst_index", 64'(index_out), 64'(0));
    chk("rst_channel", 64'(channel_out), 64'(0));
    chk("rst_error", 64'(error_out), 64'(0));
    chk("rst_ready", 64'(ready_out), 64'(1));
    @(posedge clk_in);
    #1 rst_in = 1'b0;

    // block A: DC -5, EOB fill
    push(-5, 0, 0, 0);     send(1, 0, 3, 2, 0);
    push_zeros(1, 63, 0);  send(0, 0, 0, 0, 0);

    // block B: DC delta -2, run 2 then +9, ZRL with a 5-cycle stall
    push(-2, 0, 0, 0);     send(1, 0, 2, 3, 0);
    push_zeros(1, 2, 0);   push(9, 3, 0, 0); send(0, 0, 4, 9, 2);
    push_zeros(4, 19, 0);  send(0, 0, 0, 0, 15);
    ready_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      chk("stall_ready", 64'(ready_out), 64'(0));
      chk("stall_hold", 64'({valid_out, coef_out, index_out, last_out}), 64'({1'b1, 12'd0, 6'd4, 1'b0}));
    end
    @(posedge clk_in);
    #1 ready_in = 1'b1;
    push_zeros(20, 63, 0); send(0, 0, 0, 0, 0);

    // block C: ch1 predictor independent, sign boundaries, overrun from index 5
    push(1, 0, 1, 0);      send(1, 1, 1, 1, 0);
    push(-1, 1, 1, 0);     send(0, 0, 1, 0, 0);
    push(-2, 2, 1, 0);     send(0, 0, 2, 1, 0);
    push(1024, 3, 1, 0);   send(0, 0, 11, 1024, 0);
    push(-2047, 4, 1, 0);  send(0, 0, 11, 0, 0);
    push_zeros(5, 63, 1);  send(0, 0, 1, 1, 63);
    drain();
    chk("overrun_error", 64'(error_out), 64'(EXP_OVR_ERR));

    // block D: clear coinciding with DC uses pred 0; ch0 predictor then holds 5
    clear_pred_in = 1'b1;
    push(5, 0, 0, 0);      send(1, 0, 3, 5, 0);
    push_zeros(1, 63, 0);  send(0, 0, 0, 0, 0);
    push(5, 0, 0, 0);      send(1, 0, 0, 0, 0);
    push_zeros(1, 63, 0);  send(0, 0, 0, 0, 0);
    push(0, 0, 1, 0);      send(1, 1, 0, 0, 0);
    push_zeros(1, 63, 1);  send(0, 0, 0, 0, 0);

    // block G: reset mid-block discards it and clears the predictors
    push(2, 0, 2, 0);      send(1, 2, 2, 2, 0);
    drain();
    ready_in = 1'b0;
    send(0, 0, 1, 1, 10);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("midrst_valid", 64'(valid_out), 64'(0));
    chk("midrst_last", 64'(last_out), 64'(0));
    chk("midrst_index", 64'(index_out), 64'(0));
    chk("midrst_error", 64'(error_out), 64'(0));
    @(posedge clk_in);
    #1 rst_in = 1'b0; ready_in = 1'b1;
    push(0, 0, 0, 0);      send(1, 0, 0, 0, 0);
    push_zeros(1, 63, 0);  send(0, 0, 0, 0, 0);
    drain();
    chk("final_error", 64'(error_out), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/entropy_decoder_mc.md
# entropy_decoder_mc

Multi-channel, run-expanding successor to the single-stream entropy decoder in the tinycodec decode path. It accepts (value, run, size) tokens from the Huffman stage and sign-reconstructs each value from its magnitude category. DC values are delta-decoded against a per-channel predictor, and every block is expanded into a dense stream of exactly BLOCK_SIZE coefficients in zig-zag order for the dequantiser. Both sides use valid/ready handshakes, so back-pressure from dequant/IDCT propagates to the Huffman stage.

## Interface
- VALUE_WIDTH, 11: width of value_in; maximum magnitude category.
- OUT_WIDTH, 12: signed coefficient width.
- NUM_CHANNELS, 3: number of independent DC predictors (Y/Cb/Cr).
- BLOCK_SIZE, 64: coefficients per block; must be a power of two.
- DELTA_DECODE, 1: 1 = add the channel predictor to DC values; 0 = DC passes through as-is.

Ports (CW = max(1,$clog2(NUM_CHANNELS)), IW = $clog2(BLOCK_SIZE)):
- clk_in  input  1  clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- value_in  input  VALUE_WIDTH  raw magnitude bits.
- run_in  input  IW  zeros preceding the value.
- size_in  input  5  magnitude category, 0..VALUE_WIDTH.
- dc_in  input  1  token is a DC token.
- channel_in  input  CW  channel of a DC token; ignored for AC tokens.
- valid_in  input  1  token valid.
- ready_out  output  1  token accepted when valid_in && ready_out.
- clear_pred_in  input  1  restart marker: zero all predictors.
- coef_out  output  OUT_WIDTH signed  coefficient.
- index_out  output  IW  zig-zag index of coef_out.
- channel_out  output  CW  channel of the current block.
- last_out  output  1  coef_out is index BLOCK_SIZE-1.
- valid_out  output  1  output valid.
- ready_in  input  1  downstream ready.
- error_out  output  1  sticky protocol error.

## Operation
- Value reconstruction:
  - size 0 → 0.
  - Otherwise, if value_in[size-1] = 1 the result is +value_in; else it is value_in − 2^size + 1.
  - The result is sign-extended to OUT_WIDTH.
- DC: result = decoded + pred[channel_in] (wraps mod 2^OUT_WIDTH); pred[channel_in] ← result. channel_in is latched as channel_out for the block.
- FSM states:
  - S_DC: expect DC.
  - S_AC: expect AC.
  - S_RUN: emitting run zeros, then the pending value.
  - S_FILL: EOB zero fill.
- S_DC accept → emit DC at index 0 → S_AC.
- S_AC accept, non-EOB:
  - run 0 → emit value.
  - Else emit a zero, store run−1 and the value → S_RUN.
  - size 0 with run 15 (ZRL) emits 16 zeros.
- S_AC accept, EOB (size 0, run 0) → emit zeros through index BLOCK_SIZE-1 via S_FILL.
- Any coefficient emitted at index BLOCK_SIZE-1 asserts last_out, resets the index to 0 and moves to S_DC.
- Overrun (run would pass BLOCK_SIZE-1): zeros are truncated at the block end, the pending value is dropped, last_out is asserted on the final zero, and error_out is set.
- clear_pred_in: all predictors ← 0 next cycle. If it coincides with an accepted DC token, that token uses pred = 0.

## Timing
- Output register advances when !valid_out || ready_in. coef_out, index_out, channel_out and last_out are held stable while valid_out && !ready_in.
- ready_out = advance && state ∈ {S_DC, S_AC}. It is combinational from ready_in, valid_out and state.
- Latency: a token accepted at cycle N produces its first coefficient valid at N+1.
- Throughput: one coefficient per cycle; a token with run r occupies r+1 output cycles.
- Reset values: valid_out 0, last_out 0, coef_out 0, index_out 0, channel_out 0, error_out 0, state S_DC, all predictors 0.
- rst_in mid-block discards the block without emitting last_out.

## Configuration
- ENTROPY_DECODER_MC_ERROR_EN defined:
  - An AC token in S_DC, or a DC token in S_AC, is consumed and dropped, and error_out is set.
  - Overrun also sets error_out.
  - error_out clears only on rst_in.
- Undefined:
  - error_out is tied 0.
  - dc_in is ignored and each token is interpreted by the current state (S_DC ⇒ DC).
  - Overrun still truncates at the block end.

## Test plan
- DC ch0 size 3 value 2 (predictor 0) → coef −5 at index 0; then EOB → 63 zeros with last_out on index 63.
- DC ch0 size 2 value 3 after the previous block → coef −2 (3 + −5); DC ch1 size 1 value 1 → +1 (ch1 predictor independent).
- AC run 2 size 4 value 9 after DC → zeros at indices 1,2, then +9 at index 3; ZRL → 16 zeros at indices 4..19.
- Hold ready_in low for 5 cycles mid-run → outputs frozen, ready_out 0, no coefficient lost or duplicated.
- AC run 63 size 1 value 1 at index 5 → zeros through index 63 with last_out, value dropped, error_out 1 (ERROR_EN build).
- clear_pred_in with DC ch0 size 3 value 5 accepted the same cycle → coef +5; next block's DC predictor is 5.
